shift_rows_unit: RTL and testbench
==================================

SHIFT_ROWS_UNIT -- requirements
Module: shift_rows_unit

Interface
REQ-001 SHALL have parameter NB, default 4, meaning state column count (legal 4, 6, 8; block width 32*NB bits).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream block valid.
REQ-005 SHALL have port in_ready  output  1  unit can accept a block.
REQ-006 SHALL have port in_inv  input  1  1 = InvShiftRows, 0 = ShiftRows; sampled with block.
REQ-007 SHALL have port in_data  input  32*NB  state block, column-major; byte s[r][c] at bits [32*NB-1-8*(4c+r) -: 8].
REQ-008 SHALL have port out_valid  output  1  out_data holds a transformed block.
REQ-009 SHALL have port out_ready  input  1  downstream accepts.
REQ-010 SHALL have port out_data  output  32*NB  transformed block, same byte layout.

Function
REQ-011 Row offsets SHALL be C = {0,1,2,3} for NB=4 and NB=6, and {0,1,3,4} for NB=8.
REQ-012 Forward SHALL give out s'[r][c] = s[r][(c+C[r]) mod NB]; inverse SHALL give s'[r][c] = s[r][(c-C[r]) mod NB].
REQ-013 Transform SHALL be applied on write; buffer stores transformed blocks.
REQ-014 Buffer SHALL be a 2-entry FIFO; blocks leave in arrival order.
REQ-015 Accept SHALL occur when in_valid & in_ready at a rising edge; pop when out_valid & out_ready.
REQ-016 in_ready SHALL be registered: 1 iff occupancy < 2; no combinational path from out_ready to in_ready.
REQ-017 Latency SHALL be 1 cycle: block accepted at edge k drives out_valid/out_data after edge k when buffer was empty.
REQ-018 out_data SHALL be the head entry; SHALL be held stable while out_valid & !out_ready.
REQ-019 Occupancy 1 with simultaneous push and pop SHALL stay 1 with new block at head next cycle.
REQ-020 Occupancy 2 (full): in_ready=0, push ignored; pop SHALL drop occupancy to 1 and raise in_ready next cycle.
REQ-021 Empty with pop attempt SHALL have no effect; out_valid stays 0.
REQ-022 Read/write pointers SHALL wrap modulo 2.
REQ-023 in_inv SHALL be captured per block; mixed-mode streams SHALL be supported back-to-back.

Reset
REQ-024 On n_rst low, asynchronously: occupancy 0, pointers 0, out_valid 0, out_data 0, in_ready 0.
REQ-025 First edge after n_rst release SHALL set in_ready 1; reset mid-stream SHALL discard all buffered blocks.

Configuration
REQ-026 Macro SHIFT_ROWS_INV_EN defined: in_inv honoured per REQ-012.
REQ-027 Macro SHIFT_ROWS_INV_EN undefined: in_inv ignored, forward transform only, no inverse muxing synthesised.

Structure
REQ-028 Shared package aes_pkg SHALL hold NB_MAX=8, byte typedef, and the row-offset constant/function of NB.
REQ-029 Combinational permutation SHALL be sub-module shift_rows_xform (params NB, inputs data and inv); FIFO and handshake in shift_rows_unit.

Verification
REQ-030 NB=4, inv=0, in d42711aee0bf98f1b8b45de51e415230 -> out d4bf5d30e0b452aeb84111f11e2798e5, out_valid 1 cycle after accept.
REQ-031 NB=4, inv=1, in d4bf5d30e0b452aeb84111f11e2798e5 -> out d42711aee0bf98f1b8b45de51e415230.
REQ-032 NB=8, inv=0, bytes 00..1f ascending -> row3 column0 = byte at s[3][4] = 0x13, row2 column0 = s[2][3] = 0x0e.
REQ-033 out_ready=0, push 3 blocks A,B,C -> in_ready 0 after B, C stalled; raise out_ready -> A,B,C out in order, each held while stalled.
REQ-034 Continuous in_valid/out_ready, alternating inv -> one block per cycle, each correctly transformed.
REQ-035 Assert n_rst with 2 blocks buffered -> out_valid 0, out_data 0 immediately; no stale block after release.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, byte type and ShiftRows row offsets.
// Used by shift_rows_xform and shift_rows_unit.
package aes_pkg;

  localparam int NB_MAX = 8;

  typedef logic [7:0] byte_t;

  // Row r rotates by r columns, except the 256-bit state, where rows 2 and 3 use offsets 3 and 4.
  function automatic int row_offset(input int nb, input int r);
    return (nb == NB_MAX && r >= 2) ? r + 1 : r;
  endfunction

  // MSB position of byte s[r][c] in a column-major block of nb columns.
  function automatic int byte_msb(input int nb, input int r, input int c);
    return 32 * nb - 1 - 8 * (4 * c + r);
  endfunction

endpackage

// File: rtl/shift_rows_xform.sv
// Combinational ShiftRows / InvShiftRows permutation of one state block.
// The inverse path exists only when SHIFT_ROWS_INV_EN is defined; otherwise inv is ignored.
module shift_rows_xform
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] data,
  input  logic             inv,
  output logic [32*NB-1:0] result
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int FWD_SRC = (c + row_offset(NB, r)) % NB;

      byte_t w_fwd;
      assign w_fwd = data[byte_msb(NB, r, FWD_SRC) -: 8];

`ifdef SHIFT_ROWS_INV_EN
      localparam int INV_SRC = (c + NB - row_offset(NB, r)) % NB;

      byte_t w_inv;
      assign w_inv = data[byte_msb(NB, r, INV_SRC) -: 8];
      assign result[byte_msb(NB, r, c) -: 8] = inv ? w_inv : w_fwd;
`else
      assign result[byte_msb(NB, r, c) -: 8] = w_fwd;
`endif
    end
  end

`ifndef SHIFT_ROWS_INV_EN
  // Forward-only build: the mode input has no load.
  logic w_unused_inv;
  assign w_unused_inv = inv;
`endif

endmodule

// File: rtl/shift_rows_unit.sv
// ShiftRows stage with a 2-entry output FIFO; blocks are transformed on write.
// Define SHIFT_ROWS_INV_EN to honour in_inv (InvShiftRows); otherwise forward only.
module shift_rows_unit
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [32*NB-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32*NB-1:0] out_data
);

  localparam int W = 32 * NB;

  logic [W-1:0] w_xform_data;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_count_next;

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         r_in_ready;

  shift_rows_xform #(
    .NB (NB)
  ) u_xform (
    .data   (in_data),
    .inv    (in_inv),
    .result (w_xform_data)
  );

  assign w_push       = in_valid & r_in_ready;
  assign w_pop        = out_valid & out_ready;
  assign w_count_next = r_count + 2'(w_push) - 2'(w_pop);

  // in_ready comes from a flop, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count    <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_in_ready <= 1'b0;
      // NOTE: the storage is reset too, so out_data reads 0 while n_rst is low.
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
    end else begin
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next < 2'd2);
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_xform_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_shift_rows_unit.sv
// Scoreboard bench for shift_rows_unit: a driver queues expected blocks on accept,
// a negedge monitor pops and compares whenever a block leaves the DUT.
module tb_shift_rows_unit;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [127:0] in_data, out_data;

  logic         in_valid8, in_ready8, out_valid8;
  logic [255:0] in_data8, out_data8;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q[$];
  logic [127:0] mon_exp;
  logic [127:0] held;
  bit           stalled = 1'b0;

  always #5 clk = ~clk;

  shift_rows_unit #(.NB(4)) u_dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  shift_rows_unit #(.NB(8)) u_dut8 (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_inv    (1'b0),
    .in_data   (in_data8),
    .out_valid (out_valid8),
    .out_ready (1'b1),
    .out_data  (out_data8)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit eff_inv(input bit inv);
`ifdef SHIFT_ROWS_INV_EN
    return inv;
`else
    return 1'b0;
`endif
  endfunction

  // Reference permutation written straight from the row-offset table.
  function automatic logic [255:0] ref_sr(input logic [255:0] d, input bit inv, input int nb);
    logic [255:0] o;
    int off, src, w;
    o = '0;
    w = 32 * nb;
    for (int r = 0; r < 4; r++) begin
      off = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - off + nb) % nb : (c + off) % nb;
        o[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] exp4(input logic [127:0] d, input bit inv);
    logic [255:0] t;
    t = ref_sr({128'b0, d}, eff_inv(inv), 4);
    return t[127:0];
  endfunction

  // Monitor: pops on every transfer, checks head stability on every stalled cycle.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 256'(out_valid), 256'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_data", 256'(out_data), 256'(mon_exp));
      end
      stalled = 1'b0;
    end else if (out_valid) begin
      if (stalled) check("stall_hold", 256'(out_data), 256'(held));
      held    = out_data;
      stalled = 1'b1;
    end else begin
      stalled = 1'b0;
    end
  end

  // Starts and ends on a rising edge; leaves in_valid high for back-to-back use.
  task automatic send(input logic [127:0] d, input bit inv, input logic [127:0] exp,
                      output int waited);
    bit acc;
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    waited   = 0;
    acc      = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      waited++;
    end
    if (acc) exp_q.push_back(exp);
    else check("accept_timeout", 256'(acc), 256'd1);
  endtask

  task automatic drop();
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    check("drain", 256'(exp_q.size()), 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] vec [6];
    logic [127:0] e31;
    logic [255:0] asc8, e8;
    int w, total;
    bit got8;

    n_rst = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid8 = 1'b0; in_data8 = '0;

    #12;
    check("rst_out_valid", 256'(out_valid), 256'd0);
    check("rst_in_ready", 256'(in_ready), 256'd0);
    check("rst_out_data", 256'(out_data), 256'd0);
    @(negedge clk);
    n_rst = 1'b1;
    #1 check("ready_before_edge", 256'(in_ready), 256'd0);
    @(posedge clk);
    #1 check("ready_after_release", 256'(in_ready), 256'd1);

    // NB=8 instance: ascending bytes 00..1f, forward.
    for (int k = 0; k < 32; k++) asc8[255-8*k -: 8] = 8'(k);
    in_valid8 = 1'b1;
    in_data8  = asc8;
    got8 = 1'b0;
    for (int i = 0; i < 10 && !got8; i++) begin
      @(negedge clk);
      got8 = in_ready8;
      @(posedge clk);
    end
    #1 in_valid8 = 1'b0;
    got8 = 1'b0;
    for (int i = 0; i < 5 && !got8; i++) begin
      @(negedge clk);
      got8 = out_valid8;
    end
    e8 = ref_sr(asc8, 1'b0, 8);
    check("nb8_valid", 256'(out_valid8), 256'd1);
    check("nb8_r3c0", 256'(out_data8[231:224]), 256'h13);
    check("nb8_r2c0", 256'(out_data8[239:232]), 256'h0e);
    check("nb8_r1c0", 256'(out_data8[247:240]), 256'h05);
    check("nb8_full", out_data8, e8);
    @(posedge clk);

    // Single blocks, buffer empty: one-cycle latency.
    out_ready = 1'b1;
    send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0,
         128'hd4bf5d30e0b452aeb84111f11e2798e5, w);
    drop();
    @(negedge clk);
    check("latency_out_valid", 256'(out_valid), 256'd1);
    @(posedge clk);

`ifdef SHIFT_ROWS_INV_EN
    e31 = 128'hd42711aee0bf98f1b8b45de51e415230;
`else
    e31 = exp4(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0);
`endif
    send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, e31, w);
    drop();
    @(posedge clk);
    send(128'h000102030405060708090a0b0c0d0e0f, 1'b0,
         128'h00050a0f04090e03080d02070c01060b, w);
    drop();
    wait_drain();

    // Stall: A and B fill the buffer, C waits until a pop frees a slot.
    #1 out_ready = 1'b0;
    send(128'h11111111222222223333333344444444, 1'b0,
         exp4(128'h11111111222222223333333344444444, 1'b0), w);
    send(128'h0123456789abcdeffedcba9876543210, 1'b1,
         exp4(128'h0123456789abcdeffedcba9876543210, 1'b1), w);
    #1 in_data = 128'hdeadbeef0badf00dcafebabe12345678; in_inv = 1'b0;
    @(negedge clk);
    check("full_in_ready", 256'(in_ready), 256'd0);
    check("full_head", 256'(out_data), 256'(exp4(128'h11111111222222223333333344444444, 1'b0)));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("full_stall_in_ready", 256'(in_ready), 256'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("ready_before_pop", 256'(in_ready), 256'd0);
    exp_q.push_back(exp4(128'hdeadbeef0badf00dcafebabe12345678, 1'b0));
    @(posedge clk);
    @(negedge clk);
    check("ready_after_pop", 256'(in_ready), 256'd1);
    @(posedge clk);
    drop();
    wait_drain();

    // Pop attempts on an empty buffer change nothing.
    repeat (3) begin
      @(negedge clk);
      check("empty_pop", 256'(out_valid), 256'd0);
    end
    @(posedge clk);
    send(128'h000102030405060708090a0b0c0d0e0f, 1'b0,
         128'h00050a0f04090e03080d02070c01060b, w);
    drop();
    wait_drain();

    // Back-to-back stream with alternating mode.
    vec[0] = 128'hd42711aee0bf98f1b8b45de51e415230;
    vec[1] = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    vec[2] = 128'h000102030405060708090a0b0c0d0e0f;
    vec[3] = 128'h00112233445566778899aabbccddeeff;
    vec[4] = 128'h0123456789abcdeffedcba9876543210;
    vec[5] = 128'hdeadbeef0badf00dcafebabe12345678;
    total = 0;
    for (int i = 0; i < 6; i++) begin
      send(vec[i], 1'(i % 2), exp4(vec[i], 1'(i % 2)), w);
      total += w;
    end
    drop();
    check("throughput_cycles", 256'(total), 256'd6);
    wait_drain();

    // Reset with two blocks buffered.
    #1 out_ready = 1'b0;
    send(vec[3], 1'b0, exp4(vec[3], 1'b0), w);
    send(vec[4], 1'b1, exp4(vec[4], 1'b1), w);
    drop();
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    check("midrst_out_valid", 256'(out_valid), 256'd0);
    check("midrst_out_data", 256'(out_data), 256'd0);
    check("midrst_in_ready", 256'(in_ready), 256'd0);
    exp_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_stale", 256'(out_valid), 256'd0);
    end
    check("ready_after_midrst", 256'(in_ready), 256'd1);
    @(posedge clk);
    send(vec[5], 1'b1, exp4(vec[5], 1'b1), w);
    drop();
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
